// File: rtl/mem_harness_ctrl.sv
// Run controller for RAM-backed HLS kernels: preloads operands over the RAM debug write port,
// releases the kernel until it reports valid, then checks result words against an expected table.
module mem_harness_ctrl #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned N_INIT     = 12,
    parameter int unsigned CHECK_BASE = 12,
    parameter int unsigned N_CHECK    = 3,
    parameter int unsigned MAX_RUN    = 100
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic [ADDR_W-1:0] tbl_idx_o,
    input  logic [DATA_W-1:0] tbl_init_data_i,
    input  logic [DATA_W-1:0] tbl_exp_data_i,
    output logic              dbg_wr_en_o,
    output logic [ADDR_W-1:0] dbg_wr_addr_o,
    output logic [DATA_W-1:0] dbg_wr_data_o,
    output logic [ADDR_W-1:0] dbg_addr_o,
    input  logic [DATA_W-1:0] dbg_data_i,
    output logic              dut_rst_o,
    input  logic              dut_valid_i,
    output logic              done_o,
    output logic              pass_o,
    output logic [1:0]        fail_code_o,
    output logic [ADDR_W-1:0] fail_idx_o,
    output logic [31:0]       run_cycles_o
);

    // One extra bit so k can count a full 2^ADDR_W-word table without wrapping.
    localparam int unsigned       KW        = ADDR_W + 1;
    localparam logic [KW-1:0]     LastInit  = KW'(N_INIT - 1);
    localparam logic [KW-1:0]     LastCheck = KW'(N_CHECK - 1);
    localparam logic [ADDR_W-1:0] Base      = ADDR_W'(CHECK_BASE);
    localparam logic [31:0]       MaxRun    = 32'(MAX_RUN);

    localparam logic [1:0] FailNone    = 2'd0;
    localparam logic [1:0] FailTimeout = 2'd1;
    localparam logic [1:0] FailData    = 2'd2;
    localparam logic [1:0] FailValid   = 2'd3;

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StCheck, StDone} state_e;

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic              cmp_q, cmp_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              dut_rst_q, dut_rst_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [1:0]        fail_code_q, fail_code_d;
    logic [ADDR_W-1:0] fail_idx_q, fail_idx_d;
    logic [31:0]       run_q, run_d;

    logic [ADDR_W-1:0] chk_addr;
    logic [31:0]       run_inc;
    logic              launch;

    assign chk_addr = Base + k_q[ADDR_W-1:0];
    assign run_inc  = (run_q == '1) ? run_q : run_q + 32'd1;
    assign launch   = start_i && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cmp_d       = cmp_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        dut_rst_d   = dut_rst_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_code_d = fail_code_q;
        fail_idx_d  = fail_idx_q;
        run_d       = run_q;
        tbl_idx_o   = '0;

        unique case (state_q)
            StIdle: begin
                dut_rst_d = 1'b1;
            end
            StLoad: begin
                tbl_idx_o = k_q[ADDR_W-1:0];
                wr_en_d   = 1'b1;
                wr_addr_d = k_q[ADDR_W-1:0];
                wr_data_d = tbl_init_data_i;
                dut_rst_d = 1'b1;
                if (k_q == LastInit) begin
                    state_d = StRun;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StRun: begin
                dut_rst_d = 1'b0;
                if (dut_valid_i) begin
                    state_d = StCheck;
                    k_d     = '0;
                    cmp_d   = 1'b0;
                end else begin
                    run_d = run_inc;
                    if (run_inc >= MaxRun) begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        fail_code_d = FailTimeout;
                    end
                end
            end
            StCheck: begin
                dut_rst_d = 1'b0;
                tbl_idx_o = chk_addr;
                if (!cmp_q) begin
                    // First cycle only issues the read; the compare pipeline starts next cycle.
                    rd_addr_d = chk_addr;
                    cmp_d     = 1'b1;
                    if (!dut_valid_i) begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        fail_code_d = FailValid;
                    end else if (N_CHECK == 0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end
                end else if (dbg_data_i != tbl_exp_data_i) begin
                    state_d     = StDone;
                    done_d      = 1'b1;
                    fail_code_d = FailData;
                    fail_idx_d  = chk_addr;
                end else if (!dut_valid_i) begin
                    state_d     = StDone;
                    done_d      = 1'b1;
                    fail_code_d = FailValid;
                end else if (k_q == LastCheck) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else begin
                    k_d       = k_q + KW'(1);
                    rd_addr_d = chk_addr + ADDR_W'(1);
                end
            end
            StDone: begin
                dut_rst_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (launch) begin
            state_d     = (N_INIT == 0) ? StRun : StLoad;
            k_d         = '0;
            cmp_d       = 1'b0;
            dut_rst_d   = 1'b1;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            fail_code_d = FailNone;
            fail_idx_d  = '0;
            run_d       = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            k_q         <= '0;
            cmp_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            dut_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= FailNone;
            fail_idx_q  <= '0;
            run_q       <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cmp_q       <= cmp_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            dut_rst_q   <= dut_rst_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_code_q <= fail_code_d;
            fail_idx_q  <= fail_idx_d;
            run_q       <= run_d;
        end
    end

    assign dbg_wr_en_o   = wr_en_q;
    assign dbg_wr_addr_o = wr_addr_q;
    assign dbg_wr_data_o = wr_data_q;
    assign dbg_addr_o    = rd_addr_q;
    assign dut_rst_o     = dut_rst_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign fail_code_o   = fail_code_q;
    assign fail_idx_o    = fail_idx_q;
    assign run_cycles_o  = run_q;

endmodule

// File: tb/tb_mem_harness_ctrl.sv
// Bench for mem_harness_ctrl: RAM and mvmul kernel models plus a timeline model of each sequence,
// checked every cycle, with literal expectations for the directed scenarios.
module tb_mem_harness_ctrl;

    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int N_INIT     = 12;
    localparam int CHECK_BASE = 12;
    localparam int N_CHECK    = 3;
    localparam int MAX_RUN    = 100;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b1;
    logic              start_i = 1'b0;
    logic              dut_valid_i = 1'b0;
    logic [ADDR_W-1:0] tbl_idx_o;
    logic [DATA_W-1:0] tbl_init_data_i;
    logic [DATA_W-1:0] tbl_exp_data_i;
    logic              dbg_wr_en_o;
    logic [ADDR_W-1:0] dbg_wr_addr_o;
    logic [DATA_W-1:0] dbg_wr_data_o;
    logic [ADDR_W-1:0] dbg_addr_o;
    logic [DATA_W-1:0] dbg_data_i;
    logic              dut_rst_o;
    logic              done_o;
    logic              pass_o;
    logic [1:0]        fail_code_o;
    logic [ADDR_W-1:0] fail_idx_o;
    logic [31:0]       run_cycles_o;

    logic [DATA_W-1:0] init_tbl [32];
    logic [DATA_W-1:0] exp_tbl  [32];
    logic [DATA_W-1:0] ram      [32];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int s_cyc   = 0;
    bit active  = 1'b0;

    // Model of the current sequence, in cycles relative to the first cycle after start is taken.
    int m_v, m_d, m_term, m_fail, m_pass, m_idx, m_run, m_lastj;
    int kres [N_CHECK];

    int                c_rel;
    logic [ADDR_W-1:0] c_idx;
    bit                c_we;

    mem_harness_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .N_INIT    (N_INIT),
        .CHECK_BASE(CHECK_BASE),
        .N_CHECK   (N_CHECK),
        .MAX_RUN   (MAX_RUN)
    ) u_dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .tbl_idx_o      (tbl_idx_o),
        .tbl_init_data_i(tbl_init_data_i),
        .tbl_exp_data_i (tbl_exp_data_i),
        .dbg_wr_en_o    (dbg_wr_en_o),
        .dbg_wr_addr_o  (dbg_wr_addr_o),
        .dbg_wr_data_o  (dbg_wr_data_o),
        .dbg_addr_o     (dbg_addr_o),
        .dbg_data_i     (dbg_data_i),
        .dut_rst_o      (dut_rst_o),
        .dut_valid_i    (dut_valid_i),
        .done_o         (done_o),
        .pass_o         (pass_o),
        .fail_code_o    (fail_code_o),
        .fail_idx_o     (fail_idx_o),
        .run_cycles_o   (run_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    assign tbl_init_data_i = init_tbl[tbl_idx_o];
    assign tbl_exp_data_i  = exp_tbl[tbl_idx_o];
    assign dbg_data_i      = ram[dbg_addr_o];

    // RAM behind the debug port; the kernel deposits its results on the edge that starts cycle m_v.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (dbg_wr_en_o) ram[dbg_wr_addr_o] <= dbg_wr_data_o;
        if (active && (cyc - s_cyc - 1) == m_v - 1) begin
            for (int i = 0; i < N_CHECK; i++) ram[CHECK_BASE + i] <= kres[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // v: first cycle dut_valid is high; d: cycle it pulses low (-1 for none).
    task automatic plan(input int v, input int d);
        for (int i = 0; i < N_CHECK; i++) begin
            kres[i] = 0;
            for (int j = 0; j < 3; j++)
                kres[i] += int'(init_tbl[3 * i + j]) * int'(init_tbl[9 + j]);
        end
        m_v     = v;
        m_d     = d;
        m_idx   = 0;
        m_lastj = N_CHECK - 1;
        if (v > N_INIT + MAX_RUN - 1) begin
            m_fail = 1;
            m_pass = 0;
            m_run  = MAX_RUN;
            m_term = N_INIT + MAX_RUN - 1;
        end else begin
            m_fail = 0;
            m_pass = 1;
            m_run  = v - N_INIT;
            m_term = v + 1 + N_CHECK;
            for (int j = 0; j < N_CHECK; j++) begin
                if (m_fail == 0 && kres[j] != int'(exp_tbl[CHECK_BASE + j])) begin
                    m_fail  = 2;
                    m_pass  = 0;
                    m_idx   = CHECK_BASE + j;
                    m_lastj = j;
                    m_term  = v + 2 + j;
                end
            end
            if (d >= v + 1 && (d < m_term || (d == m_term && m_fail != 2))) begin
                m_fail = 3;
                m_pass = 0;
                m_idx  = 0;
                m_term = d;
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (active) begin
            c_rel = cyc - s_cyc - 1;
            if (c_rel >= 0 && c_rel <= m_term + 1) begin
                chk("dut_rst", 32'(dut_rst_o), 32'(c_rel <= N_INIT));
                c_we = (c_rel >= 1 && c_rel <= N_INIT);
                chk("wr_en", 32'(dbg_wr_en_o), 32'(c_we));
                if (c_we) begin
                    chk("wr_addr", 32'(dbg_wr_addr_o), 32'(c_rel - 1));
                    chk("wr_data", dbg_wr_data_o, init_tbl[c_rel - 1]);
                end
                if (c_rel < N_INIT) c_idx = ADDR_W'(c_rel);
                else if (m_fail == 1 || c_rel <= m_v || c_rel > m_term) c_idx = '0;
                else c_idx = ADDR_W'(CHECK_BASE + ((c_rel - m_v - 2 > 0) ? c_rel - m_v - 2 : 0));
                chk("tbl_idx", 32'(tbl_idx_o), 32'(c_idx));
                chk("done", 32'(done_o), 32'(c_rel > m_term));
                if (c_rel > m_term) begin
                    chk("pass", 32'(pass_o), 32'(m_pass));
                    chk("fail_code", 32'(fail_code_o), 32'(m_fail));
                    chk("fail_idx", 32'(fail_idx_o), 32'(m_idx));
                    chk("run_cycles", run_cycles_o, 32'(m_run));
                end else begin
                    chk("pass_early", 32'(pass_o), 32'd0);
                    chk("fail_early", 32'(fail_code_o), 32'd0);
                end
                if (m_fail != 1 && m_fail != 3 && c_rel >= m_v + 2) begin
                    c_idx = ADDR_W'(CHECK_BASE +
                                    ((c_rel - m_v - 2 < m_lastj) ? c_rel - m_v - 2 : m_lastj));
                    chk("dbg_addr", 32'(dbg_addr_o), 32'(c_idx));
                end
            end
        end
    end

    task automatic run_seq(input int v, input int d, input bit lit);
        int rel;
        plan(v, d);
        @(negedge clk_i);
        dut_valid_i = 1'b0;
        start_i     = 1'b1;
        s_cyc       = cyc;
        active      = 1'b1;
        for (int n = 0; n <= m_term + 2; n++) begin
            @(negedge clk_i);
            start_i     = 1'b0;
            rel         = cyc - s_cyc - 1;
            dut_valid_i = (rel >= v && rel != d);
            if (lit && rel == 12) begin
                chk("lit_last_wr_en", 32'(dbg_wr_en_o), 32'd1);
                chk("lit_last_wr_addr", 32'(dbg_wr_addr_o), 32'd11);
                chk("lit_rst_still_high", 32'(dut_rst_o), 32'd1);
            end
            if (lit && rel == 13) begin
                chk("lit_wr_en_fall", 32'(dbg_wr_en_o), 32'd0);
                chk("lit_rst_fall", 32'(dut_rst_o), 32'd0);
            end
        end
        active = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, 32'(dbg_wr_en_o), 32'd0);
        chk({tag, "_wr_addr"}, 32'(dbg_wr_addr_o), 32'd0);
        chk({tag, "_wr_data"}, dbg_wr_data_o, 32'd0);
        chk({tag, "_dbg_addr"}, 32'(dbg_addr_o), 32'd0);
        chk({tag, "_dut_rst"}, 32'(dut_rst_o), 32'd1);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_pass"}, 32'(pass_o), 32'd0);
        chk({tag, "_fail_code"}, 32'(fail_code_o), 32'd0);
        chk({tag, "_fail_idx"}, 32'(fail_idx_o), 32'd0);
        chk({tag, "_run_cycles"}, run_cycles_o, 32'd0);
        chk({tag, "_tbl_idx"}, 32'(tbl_idx_o), 32'd0);
    endtask

    initial begin
        int init_vals [12] = '{6, 1, 2, 3, 7, 5, 5, 2, 9, 9, 3, 7};
        for (int i = 0; i < 32; i++) begin
            init_tbl[i] = '0;
            exp_tbl[i]  = '0;
        end
        for (int i = 0; i < 12; i++) init_tbl[i] = DATA_W'(init_vals[i]);
        exp_tbl[12] = 32'd71;
        exp_tbl[13] = 32'd83;
        exp_tbl[14] = 32'd114;

        #1 rst_ni = 1'b0;
        #2 check_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // mvmul golden run
        run_seq(17, -1, 1'b1);
        chk("golden_done", 32'(done_o), 32'd1);
        chk("golden_pass", 32'(pass_o), 32'd1);
        chk("golden_fail_code", 32'(fail_code_o), 32'd0);
        chk("golden_run_cycles", run_cycles_o, 32'd5);

        // timeout with valid tied low
        run_seq(1000, -1, 1'b0);
        chk("timeout_fail_code", 32'(fail_code_o), 32'd1);
        chk("timeout_run_cycles", run_cycles_o, 32'd100);
        chk("timeout_pass", 32'(pass_o), 32'd0);

        // data mismatch at word 13
        exp_tbl[13] = 32'd84;
        run_seq(17, -1, 1'b0);
        exp_tbl[13] = 32'd83;
        chk("mismatch_fail_code", 32'(fail_code_o), 32'd2);
        chk("mismatch_fail_idx", 32'(fail_idx_o), 32'd13);
        chk("mismatch_last_addr", 32'(dbg_addr_o), 32'd13);

        // valid drops during CHECK
        run_seq(17, 19, 1'b0);
        chk("drop_fail_code", 32'(fail_code_o), 32'd3);
        chk("drop_done", 32'(done_o), 32'd1);

        // valid rises on the cycle the budget expires
        run_seq(N_INIT + MAX_RUN - 1, -1, 1'b0);
        chk("edge_pass", 32'(pass_o), 32'd1);
        chk("edge_run_cycles", run_cycles_o, 32'd99);

        // asynchronous abort mid-LOAD, then a full rerun
        @(negedge clk_i);
        dut_valid_i = 1'b0;
        start_i     = 1'b1;
        repeat (6) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
        chk("abort_tbl_idx_k5", 32'(tbl_idx_o), 32'd5);
        chk("abort_wr_addr_pre", 32'(dbg_wr_addr_o), 32'd4);
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_seq(17, -1, 1'b1);
        chk("rerun_pass", 32'(pass_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
